// File: rtl/limb_mult_pkg.sv
// Shared helpers for the limb-serial multiplier: stage-count arithmetic and mod-3 residues.
// The residue helpers are only used when LIMB_MULT_PIPE_RESIDUE_CHECK_EN is defined.
package limb_mult_pkg;

    localparam int RES_MAX_BITS = 1024;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // 4 == 1 (mod 3), so summing 2-bit groups preserves the residue
    function automatic logic [1:0] residue_mod3(input logic [RES_MAX_BITS-1:0] x);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < RES_MAX_BITS / 2; i++) begin
            r = r + {1'b0, x[2*i +: 2]};
            if (r >= 3'd3) begin
                r = r - 3'd3;
            end else begin
                r = r;
            end
        end
        return r[1:0];
    endfunction

    function automatic logic [1:0] mul_mod3(input logic [1:0] ra, input logic [1:0] rb);
        logic [3:0] p;
        logic [1:0] r;
        p = {2'b00, ra} * {2'b00, rb};
        case (p)
            4'd0:    r = 2'd0;
            4'd1:    r = 2'd1;
            4'd2:    r = 2'd2;
            4'd3:    r = 2'd0;
            4'd4:    r = 2'd1;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/if_axi_stream.sv
// Stream bundle used between the Barrett reducer and its multiplier.
// master: the multiplier's request side (reads beats, drives rdy); slave: its response side.
interface if_axi_stream #(
    parameter int DAT_BITS = 64,
    parameter int CTL_BITS = 8
);
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;

    modport master (input val, input dat, input ctl, input sop, input eop, output rdy);
    modport slave  (output val, output dat, output ctl, output sop, output eop, input rdy);
endinterface

// File: rtl/limb_mult_row.sv
// One registered schoolbook row: acc + (a * limb) << ((ROW-1)*LIMB_BITS).
// Holds its contents while adv is low; valid is the only reset state.
module limb_mult_row
    import limb_mult_pkg::*;
#(
    parameter int DAT_BITS  = 381,
    parameter int LIMB_BITS = 64,
    parameter int CTL_BITS  = 8,
    parameter int ROW       = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    adv,
    input  logic                    src_val,
    input  logic [CTL_BITS-1:0]     src_ctl,
    input  logic [DAT_BITS-1:0]     src_a,
    input  logic [LIMB_BITS-1:0]    src_limb,
    input  logic [2*DAT_BITS-1:0]   src_acc,
    output logic                    val_r,
    output logic [CTL_BITS-1:0]     ctl_r,
    output logic [2*DAT_BITS-1:0]   acc_r
);

    localparam int PRD_BITS = 2 * DAT_BITS;
    localparam int SHIFT    = (ROW - 1) * LIMB_BITS;

    logic [DAT_BITS+LIMB_BITS-1:0] part_s;
    logic [PRD_BITS-1:0]           term_s;
    logic [PRD_BITS-1:0]           sum_s;

    // partial product for this row; running sum never exceeds 2*DAT_BITS bits
    always_comb begin
        part_s = {{LIMB_BITS{1'b0}}, src_a} * {{DAT_BITS{1'b0}}, src_limb};
        term_s = PRD_BITS'(part_s) << SHIFT;
        sum_s  = src_acc + term_s;
    end

    // stage valid
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            val_r <= 1'b0;
        end else if (adv) begin
            val_r <= src_val;
        end
    end

    // stage payload, deliberately not reset
    always_ff @(posedge i_clk) begin
        if (adv) begin
            ctl_r <= src_ctl;
            acc_r <= sum_s;
        end
    end

endmodule

// File: rtl/limb_mult_pipe.sv
// Pipelined limb-serial unsigned multiplier with valid/ready backpressure on both stream ports.
// Optional mod-3 residue self-check enabled by defining LIMB_MULT_PIPE_RESIDUE_CHECK_EN.
module limb_mult_pipe
    import limb_mult_pkg::*;
#(
    parameter int DAT_BITS  = 381,
    parameter int LIMB_BITS = 64,
    parameter int CTL_BITS  = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    if_axi_stream.master  i_mul_if,
    if_axi_stream.slave   o_mul_if,
    output logic          o_err
);

    localparam int NL       = ceil_div(DAT_BITS, LIMB_BITS);
    localparam int B_BITS   = NL * LIMB_BITS;
    localparam int PRD_BITS = 2 * DAT_BITS;

    logic                adv_s [0:NL];
    logic                val_s [0:NL];
    logic [CTL_BITS-1:0] ctl_s [0:NL];
    logic [PRD_BITS-1:0] acc_s [0:NL];
    logic [DAT_BITS-1:0] a_r   [0:NL-1];
    logic [B_BITS-1:0]   b_r   [0:NL-1];
    logic                val0_r;
    logic [CTL_BITS-1:0] ctl0_r;

    assign val_s[0] = val0_r;
    assign ctl_s[0] = ctl0_r;
    assign acc_s[0] = '0;

    // stage k may load when some stage at or below it is empty, or the output drains
    always_comb begin
        logic full_v;
        full_v = 1'b1;
        for (int k = NL; k >= 0; k--) begin
            full_v   = full_v & val_s[k];
            adv_s[k] = ~full_v | o_mul_if.rdy;
        end
    end

    // S0 valid
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            val0_r <= 1'b0;
        end else if (adv_s[0]) begin
            val0_r <= i_mul_if.val;
        end
    end

    // S0 operand capture; b is zero-extended so the top limb is well defined
    always_ff @(posedge i_clk) begin
        if (adv_s[0]) begin
            a_r[0] <= i_mul_if.dat[0 +: DAT_BITS];
            b_r[0] <= B_BITS'(i_mul_if.dat[DAT_BITS +: DAT_BITS]);
            ctl0_r <= i_mul_if.ctl;
        end
    end

    for (genvar k = 1; k < NL; k++) begin : g_opnd
        // operands ride alongside the rows that still need them
        always_ff @(posedge i_clk) begin
            if (adv_s[k]) begin
                a_r[k] <= a_r[k-1];
                b_r[k] <= b_r[k-1];
            end
        end
    end

    for (genvar k = 1; k <= NL; k++) begin : g_row
        limb_mult_row #(
            .DAT_BITS  (DAT_BITS),
            .LIMB_BITS (LIMB_BITS),
            .CTL_BITS  (CTL_BITS),
            .ROW       (k)
        ) u_row (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .adv      (adv_s[k]),
            .src_val  (val_s[k-1]),
            .src_ctl  (ctl_s[k-1]),
            .src_a    (a_r[k-1]),
            .src_limb (b_r[k-1][(k-1)*LIMB_BITS +: LIMB_BITS]),
            .src_acc  (acc_s[k-1]),
            .val_r    (val_s[k]),
            .ctl_r    (ctl_s[k]),
            .acc_r    (acc_s[k])
        );
    end

    // the last row is the output register; every beat is a single-beat packet
    assign i_mul_if.rdy = adv_s[0];
    assign o_mul_if.val = val_s[NL];
    assign o_mul_if.sop = val_s[NL];
    assign o_mul_if.eop = val_s[NL];
    assign o_mul_if.dat = acc_s[NL];
    assign o_mul_if.ctl = ctl_s[NL];

`ifdef LIMB_MULT_PIPE_RESIDUE_CHECK_EN
    logic [1:0] ra_r [0:NL];
    logic [1:0] rb_r [0:NL];
    logic       err_r;

    // S0 operand residues
    always_ff @(posedge i_clk) begin
        if (adv_s[0]) begin
            ra_r[0] <= residue_mod3(RES_MAX_BITS'(i_mul_if.dat[0 +: DAT_BITS]));
            rb_r[0] <= residue_mod3(RES_MAX_BITS'(i_mul_if.dat[DAT_BITS +: DAT_BITS]));
        end
    end

    for (genvar k = 1; k <= NL; k++) begin : g_res
        // residues advance in lock-step with the row they describe
        always_ff @(posedge i_clk) begin
            if (adv_s[k]) begin
                ra_r[k] <= ra_r[k-1];
                rb_r[k] <= rb_r[k-1];
            end
        end
    end

    // sticky flag on any accepted product whose residue disagrees
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_r <= 1'b0;
        end else if (val_s[NL] && o_mul_if.rdy &&
                     (mul_mod3(ra_r[NL], rb_r[NL]) != residue_mod3(RES_MAX_BITS'(acc_s[NL])))) begin
            err_r <= 1'b1;
        end
    end

    assign o_err = err_r;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_limb_mult_pipe.sv
// Scoreboard bench for limb_mult_pipe at DAT_BITS=32, LIMB_BITS=16 (two row stages, latency 3).
module tb_limb_mult_pipe;

    localparam int DAT_BITS  = 32;
    localparam int LIMB_BITS = 16;
    localparam int CTL_BITS  = 8;
    localparam int NV        = 14;

    typedef struct packed {
        logic [7:0]  ctl;
        logic [63:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;

    always #5 clk = ~clk;

    if_axi_stream #(.DAT_BITS(2*DAT_BITS), .CTL_BITS(CTL_BITS)) in_if();
    if_axi_stream #(.DAT_BITS(2*DAT_BITS), .CTL_BITS(CTL_BITS)) out_if();

    limb_mult_pipe #(
        .DAT_BITS  (DAT_BITS),
        .LIMB_BITS (LIMB_BITS),
        .CTL_BITS  (CTL_BITS)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_mul_if (in_if),
        .o_mul_if (out_if),
        .o_err    (err)
    );

    // hand-computed products
    logic [31:0] vec_a [0:NV-1] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h00010000,
                                    32'hFFFFFFFF, 32'h80000000, 32'h0000FFFF, 32'h12345678,
                                    32'h0000FFFF, 32'hFFFF0000, 32'h00000003, 32'hFFFFFFFF,
                                    32'h00000100, 32'h00000ABC};
    logic [31:0] vec_b [0:NV-1] = '{32'hFFFFFFFF, 32'h12345678, 32'hDEADBEEF, 32'h00010000,
                                    32'h00000002, 32'h80000000, 32'hFFFF0000, 32'h00000010,
                                    32'h0000FFFF, 32'hFFFF0000, 32'h55555555, 32'h00010001,
                                    32'h01000000, 32'h00001000};
    logic [63:0] vec_p [0:NV-1] = '{64'hFFFFFFFE00000001, 64'h0000000000000000,
                                    64'h00000000DEADBEEF, 64'h0000000100000000,
                                    64'h00000001FFFFFFFE, 64'h4000000000000000,
                                    64'h0000FFFE00010000, 64'h0000000123456780,
                                    64'h00000000FFFE0001, 64'hFFFE000100000000,
                                    64'h00000000FFFFFFFF, 64'h00010000FFFEFFFF,
                                    64'h0000000100000000, 64'h0000000000ABC000};

    exp_t sb_q [$];
    int   pop_cyc_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;
    int   cyc      = 0;
    int   rdy_mode = 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // output ready: 0 = stall, 1 = always, 2 = random
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 2) out_if.rdy = 1'($urandom_range(0, 1));
        else               out_if.rdy = (rdy_mode == 1);
    end

    // monitor: every presented beat must match the scoreboard head, popped on handshake
    always @(negedge clk) begin
        if (!rst && out_if.val) begin
            if (sb_q.size() == 0) begin
                check64("spurious_out_val", {63'd0, out_if.val}, 64'd0);
            end else begin
                check64("out_dat", out_if.dat, sb_q[0].dat);
                check64("out_ctl", {56'd0, out_if.ctl}, {56'd0, sb_q[0].ctl});
                check64("out_sop_eop", {62'd0, out_if.sop, out_if.eop}, 64'd3);
                if (out_if.rdy) begin
                    void'(sb_q.pop_front());
                    pop_cyc_q.push_back(cyc);
                    n_pops++;
                end
            end
        end
    end

    task automatic offer(input int idx, input logic [7:0] tag, input int max_cycles, output bit acc);
        exp_t e;
        in_if.val = 1'b1;
        in_if.sop = 1'b1;
        in_if.eop = 1'b1;
        in_if.dat = {vec_b[idx], vec_a[idx]};
        in_if.ctl = tag;
        acc = 1'b0;
        for (int c = 0; c < max_cycles && !acc; c++) begin
            @(negedge clk);
            if (in_if.rdy) begin
                acc   = 1'b1;
                e.ctl = tag;
                e.dat = vec_p[idx];
                sb_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        in_if.val = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pops(input string name, input int target, input int budget);
        int c;
        c = 0;
        while (n_pops < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check64(name, n_pops, target);
        @(posedge clk);
        #1;
    endtask

    task automatic set_rdy_mode(input int m);
        @(negedge clk);
        rdy_mode = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int base;
        int idx;
        int n_acc;
        int lat;

        in_if.val = 1'b0;
        in_if.sop = 1'b0;
        in_if.eop = 1'b0;
        in_if.dat = '0;
        in_if.ctl = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        @(negedge clk);
        check64("rst_out_val", {63'd0, out_if.val}, 64'd0);
        check64("rst_out_sop", {63'd0, out_if.sop}, 64'd0);
        check64("rst_out_eop", {63'd0, out_if.eop}, 64'd0);
        check64("rst_err", {63'd0, err}, 64'd0);
        check64("rst_in_rdy", {63'd0, in_if.rdy}, 64'd1);
        @(posedge clk);
        #1;

        // 1: all-ones operands and latency
        offer(0, 8'hA5, 4, acc);
        in_if.val = 1'b0;
        check64("t1_accept", {63'd0, acc}, 64'd1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_if.val && lat < 10);
        check64("t1_latency", lat, 3);
        check64("t1_dat", out_if.dat, 64'hFFFFFFFE00000001);
        check64("t1_ctl", {56'd0, out_if.ctl}, 64'hA5);
        @(posedge clk);
        #1;
        wait_pops("t1_drain", 1, 20);

        // 2: 20 back-to-back beats, one product per cycle
        base = n_pops;
        for (int i = 0; i < 20; i++) begin
            offer(i % NV, 8'(i), 4, acc);
            check64("t2_accept_first_try", {63'd0, acc}, 64'd1);
        end
        idle(1);
        wait_pops("t2_drain", base + 20, 100);
        if (pop_cyc_q.size() >= base + 20)
            check64("t2_back_to_back", pop_cyc_q[base + 19] - pop_cyc_q[base], 19);

        // 3: output stalled for 8 cycles, input offered every cycle
        base = n_pops;
        set_rdy_mode(0);
        idx = 0;
        n_acc = 0;
        for (int c = 0; c < 8; c++) begin
            offer(idx + 3, 8'(8'h30 + idx), 1, acc);
            if (acc) begin
                n_acc++;
                idx++;
            end
        end
        @(negedge clk);
        check64("t3_held_beats", n_acc, 3);
        check64("t3_in_rdy_low", {63'd0, in_if.rdy}, 64'd0);
        check64("t3_out_val_held", {63'd0, out_if.val}, 64'd1);
        rdy_mode = 1;
        @(posedge clk);
        #1;
        while (idx < 6) begin
            offer(idx + 3, 8'(8'h30 + idx), 20, acc);
            check64("t3_accept_after_release", {63'd0, acc}, 64'd1);
            idx++;
        end
        idle(1);
        wait_pops("t3_drain", base + 6, 100);

        // 4: random input gaps and output backpressure
        base = n_pops;
        set_rdy_mode(2);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 1) == 1) idle(1);
            offer((i * 5) % NV, 8'(i), 200, acc);
            if (!acc) check64("t4_accept", {63'd0, acc}, 64'd1);
        end
        idle(1);
        set_rdy_mode(1);
        wait_pops("t4_drain", base + 500, 3000);

        // 5: reset with three beats in flight
        base = n_pops;
        set_rdy_mode(0);
        for (int i = 0; i < 3; i++) begin
            offer(i + 7, 8'(8'h50 + i), 4, acc);
            check64("t5_accept", {63'd0, acc}, 64'd1);
        end
        in_if.val = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        sb_q.delete();
        rdy_mode = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check64("t5_out_val_after_rst", {63'd0, out_if.val}, 64'd0);
        check64("t5_in_rdy_after_rst", {63'd0, in_if.rdy}, 64'd1);
        check64("t5_err_after_rst", {63'd0, err}, 64'd0);
        repeat (6) @(negedge clk);
        check64("t5_no_flushed_beats", n_pops, base);
        @(posedge clk);
        #1;
        offer(11, 8'hC3, 4, acc);
        idle(1);
        wait_pops("t5_post_rst_beat", base + 1, 20);

        // end of run
        check64("final_sb_empty", sb_q.size(), 0);
        check64("final_err", {63'd0, err}, 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
